cve2_obi_mem_responder: RTL and testbench



---
 rtl/cve2_obi_mem_responder.sv | 107 ++++++++++
 tb/tb_cve2_obi_mem_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cve2_obi_mem_responder.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | cve2_obi_mem_responder: OBI-style single-port memory with fixed-latency |
// | in-order responses, outstanding-request limit and range checking.      |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module cve2_obi_mem_responder #(
  parameter int unsigned MEM_SIZE_BYTES_UNUSED = 0,
  parameter int unsigned MemSizeBytes   = 4096,
  parameter logic [31:0] BaseAddr       = 32'h0000_0000,
  parameter int unsigned RespLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  req_i,
  output logic                                  gnt_o,
  input  logic [31:0]                           addr_i,
  input  logic                                  we_i,
  input  logic [3:0]                            be_i,
  input  logic [31:0]                           wdata_i,
  output logic                                  rvalid_o,
  output logic [31:0]                           rdata_o,
  output logic                                  err_o,
  input  logic                                  stall_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
);

  localparam int unsigned OutW     = $clog2(MaxOutstanding + 1);
  localparam int unsigned AddrBits = $clog2(MemSizeBytes);
  localparam int unsigned IdxW     = (AddrBits > 2) ? AddrBits - 2 : 1;
  localparam int unsigned NumWords = 2 ** IdxW;

  logic [31:0]      mem [NumWords];
  logic [31:0]      offset;
  logic             in_range;
  logic [IdxW-1:0]  word_idx;
  logic             accept;

  logic [RespLatency-1:0] pipe_valid;
  logic [RespLatency-1:0] pipe_err;
  logic [31:0]            pipe_data [RespLatency];

  assign offset   = addr_i - BaseAddr;
  assign in_range = offset < MemSizeBytes;
  assign word_idx = offset[IdxW+1:2];

  // A response retiring this cycle frees its slot for a same-cycle grant.
  assign gnt_o  = req_i & ~stall_i &
                  ((outstanding_o < OutW'(MaxOutstanding)) | rvalid_o);
  assign accept = req_i & gnt_o;

  always_ff @(posedge clk_i) begin
    if (accept && we_i && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) begin
          mem[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Data is zero unless the stage holds an in-range read, so rdata_o needs no gating.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < RespLatency; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_err[0]   <= accept & ~in_range;
      pipe_data[0]  <= (accept && !we_i && in_range) ? mem[word_idx] : '0;
      for (int i = 1; i < RespLatency; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_err[i]   <= pipe_err[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
    end
  end

  assign rvalid_o = pipe_valid[RespLatency-1];
  assign err_o    = pipe_err[RespLatency-1];
  assign rdata_o  = pipe_data[RespLatency-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      outstanding_o <= '0;
    end else if (accept && !rvalid_o) begin
      outstanding_o <= outstanding_o + OutW'(1);
    end else if (!accept && rvalid_o) begin
      outstanding_o <= outstanding_o - OutW'(1);
    end
  end

`ifndef SYNTHESIS
  a_ctrl_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !$isunknown({gnt_o, rvalid_o}));
  a_resp_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rvalid_o |-> !$isunknown({err_o, rdata_o}));
  a_out_limit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    outstanding_o <= OutW'(MaxOutstanding));
`endif

endmodule
`default_nettype wire

// File: tb/tb_cve2_obi_mem_responder.sv
`default_nettype none
// Bench for cve2_obi_mem_responder: two instances (latency 1 and 3) checked
// every cycle against a schedule-based model, plus directed literal checks.
module tb_cve2_obi_mem_responder;
  localparam int MAXO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic        req [2];
  logic        we [2];
  logic        stall [2];
  logic [3:0]  be [2];
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic        gnt [2];
  logic        rvalid [2];
  logic        err [2];
  logic [31:0] rdata [2];
  logic [1:0]  outst [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cve2_obi_mem_responder #(
    .MemSizeBytes(4096), .BaseAddr(32'h0), .RespLatency(1), .MaxOutstanding(2)
  ) u_dut_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[0]), .gnt_o(gnt[0]),
    .addr_i(addr[0]), .we_i(we[0]), .be_i(be[0]), .wdata_i(wdata[0]),
    .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0]),
    .stall_i(stall[0]), .outstanding_o(outst[0])
  );

  cve2_obi_mem_responder #(
    .MemSizeBytes(4096), .BaseAddr(32'h0), .RespLatency(3), .MaxOutstanding(2)
  ) u_dut_lat3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req[1]), .gnt_o(gnt[1]),
    .addr_i(addr[1]), .we_i(we[1]), .be_i(be[1]), .wdata_i(wdata[1]),
    .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1]),
    .stall_i(stall[1]), .outstanding_o(outst[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Model: responses are scheduled into a time-indexed slot table.
  int          cyc = 0;
  bit          sv [2][16];
  bit          se [2][16];
  bit          sk [2][16];
  logic [31:0] sd [2][16];
  int          cnt [2];
  logic [31:0] mm [2][1024];
  bit          kn [2][1024];

  initial begin : model
    bit rv [2];
    bit acc [2];
    logic [31:0] off;
    int s;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int d = 0; d < 2; d++) begin
          for (int j = 0; j < 16; j++) sv[d][j] = 1'b0;
          cnt[d] = 0;
        end
      end else begin
        for (int d = 0; d < 2; d++) begin
          s = cyc % 16;
          rv[d]  = sv[d][s];
          acc[d] = (req[d] === 1'b1) && (stall[d] === 1'b0) && (cnt[d] < MAXO || rv[d]);
          sv[d][s] = 1'b0;
        end
        cyc++;
        for (int d = 0; d < 2; d++) begin
          if (acc[d]) begin
            off = addr[d];
            s = (cyc + lat(d) - 1) % 16;
            sv[d][s] = 1'b1;
            se[d][s] = (off >= 32'd4096);
            sd[d][s] = (!we[d] && off < 32'd4096) ? mm[d][off[11:2]] : 32'h0;
            sk[d][s] = we[d] || (off >= 32'd4096) || kn[d][off[11:2]];
            if (we[d] && off < 32'd4096) begin
              for (int k = 0; k < 4; k++)
                if (be[d][k]) mm[d][off[11:2]][8*k +: 8] = wdata[d][8*k +: 8];
              if (be[d] == 4'hF) kn[d][off[11:2]] = 1'b1;
            end
          end
          cnt[d] = cnt[d] + (acc[d] ? 1 : 0) - (rv[d] ? 1 : 0);
        end
      end
    end
  end

  initial begin : compare
    int s;
    bit erv, eg;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        s   = cyc % 16;
        erv = rst_n && sv[d][s];
        eg  = (req[d] === 1'b1) && (stall[d] === 1'b0) && (cnt[d] < MAXO || erv);
        chk($sformatf("gnt%0d", d), 32'(gnt[d]), 32'(eg));
        chk($sformatf("rvalid%0d", d), 32'(rvalid[d]), 32'(erv));
        chk($sformatf("outstanding%0d", d), 32'(outst[d]), 32'(cnt[d]));
        if (erv) begin
          chk($sformatf("err%0d", d), 32'(err[d]), 32'(se[d][s]));
          if (sk[d][s]) chk($sformatf("rdata%0d", d), rdata[d], sd[d][s]);
        end else begin
          chk($sformatf("rdata_idle%0d", d), rdata[d], 32'h0);
        end
      end
    end
  end

  task automatic issue(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] wd);
    bit g;
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    req[d] = 1'b1; we[d] = w; addr[d] = a; be[d] = b; wdata[d] = wd;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      g = gnt[d];
      @(posedge clk); #1;
      if (g) done = 1'b1;
    end
    req[d] = 1'b0;
    if (!done) chk("grant_timeout", 32'(done), 32'd1);
  endtask

  task automatic wait_resp(input int d, output logic [31:0] dat, output logic e, output int n);
    bit found;
    found = 1'b0;
    dat = 32'h0; e = 1'b0; n = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      n++;
      if (rvalid[d] === 1'b1) begin
        dat = rdata[d]; e = err[d]; found = 1'b1;
      end
    end
    if (!found) chk("resp_timeout", 32'(found), 32'd1);
  endtask

  initial begin : main
    logic [31:0] dat;
    logic        e;
    int          n, k, nresp, maxo, last_i, lows, seen;
    logic        gl [8];
    logic        rl [8];
    logic [31:0] rseq [6];
    bit          g;

    for (int d = 0; d < 2; d++) begin
      req[d] = 0; we[d] = 0; stall[d] = 0; be[d] = 0; addr[d] = 0; wdata[d] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_gnt", 32'(gnt[0]), 32'd0);
    chk("reset_rvalid", 32'(rvalid[0]), 32'd0);
    chk("reset_rdata", rdata[0], 32'd0);
    chk("reset_err", 32'(err[0]), 32'd0);
    chk("reset_outstanding", 32'(outst[1]), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Write then read back, latency 1
    issue(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    wait_resp(0, dat, e, n);
    chk("wr_latency", 32'(n), 32'd1);
    chk("wr_err", 32'(e), 32'd0);
    chk("wr_rdata", dat, 32'd0);
    issue(0, 1'b0, 32'h10, 4'hF, 32'h0);
    wait_resp(0, dat, e, n);
    chk("rd_latency", 32'(n), 32'd1);
    chk("rd_deadbeef", dat, 32'hDEADBEEF);
    chk("rd_err", 32'(e), 32'd0);

    // Byte-enabled merge
    issue(0, 1'b1, 32'h20, 4'hF, 32'h11223344); wait_resp(0, dat, e, n);
    issue(0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD); wait_resp(0, dat, e, n);
    issue(0, 1'b0, 32'h23, 4'h0, 32'h0); wait_resp(0, dat, e, n);
    chk("be_merge", dat, 32'h11BB33DD);

    // Out of range
    issue(0, 1'b1, 32'h0, 4'hF, 32'hCAFEF00D); wait_resp(0, dat, e, n);
    issue(0, 1'b0, 32'h1000, 4'hF, 32'h0); wait_resp(0, dat, e, n);
    chk("oor_rd_err", 32'(e), 32'd1);
    chk("oor_rd_rdata", dat, 32'd0);
    issue(0, 1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF); wait_resp(0, dat, e, n);
    chk("oor_wr_err", 32'(e), 32'd1);
    issue(0, 1'b0, 32'h0, 4'hF, 32'h0); wait_resp(0, dat, e, n);
    chk("oor_word0_kept", dat, 32'hCAFEF00D);

    // Stall
    @(posedge clk); #1;
    stall[0] = 1'b1; req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_gnt", 32'(gnt[0]), 32'd0);
      chk("stall_outstanding", 32'(outst[0]), 32'd0);
      @(posedge clk); #1;
    end
    stall[0] = 1'b0;
    @(negedge clk);
    chk("unstall_gnt", 32'(gnt[0]), 32'd1);
    @(posedge clk); #1 req[0] = 1'b0;

    // Latency 3 burst with outstanding limit
    for (int w = 0; w < 6; w++) begin
      issue(1, 1'b1, 32'(w * 4), 4'hF, 32'hA5000000 + 32'(w));
      wait_resp(1, dat, e, n);
      if (w == 0) chk("lat3_latency", 32'(n), 32'd3);
    end
    @(posedge clk); #1;
    k = 0; nresp = 0; maxo = 0; last_i = -1;
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h0;
    for (int i = 0; i < 40 && (k < 6 || nresp < 6); i++) begin
      @(negedge clk);
      if (i < 8) begin gl[i] = gnt[1]; rl[i] = rvalid[1]; end
      if (int'(outst[1]) > maxo) maxo = int'(outst[1]);
      if (rvalid[1] === 1'b1 && nresp < 6) begin rseq[nresp] = rdata[1]; nresp++; end
      g = req[1] && gnt[1];
      @(posedge clk); #1;
      if (g) begin
        k++;
        if (k == 6) begin req[1] = 1'b0; last_i = i; end
        else addr[1] = 32'(k * 4);
      end
    end
    lows = 0;
    for (int i = 0; i < 8; i++) if (gl[i] === 1'b0) lows++;
    chk("burst_gnt_first", 32'(gl[1]), 32'd1);
    chk("burst_gnt_drop", 32'(gl[2]), 32'd0);
    chk("burst_rv_at_drop", 32'(rl[2]), 32'd0);
    chk("burst_gnt_back", 32'(gl[3]), 32'd1);
    chk("burst_rv_with_gnt", 32'(rl[3]), 32'd1);
    chk("burst_gnt_lows", 32'(lows), 32'd2);
    chk("burst_last_accept", 32'(last_i), 32'd7);
    chk("burst_accepts", 32'(k), 32'd6);
    chk("burst_maxout", 32'(maxo), 32'd2);
    chk("burst_nresp", 32'(nresp), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("burst_order%0d", i), rseq[i], 32'hA5000000 + 32'(i));

    // Reset with a response in flight
    issue(1, 1'b0, 32'h40, 4'hF, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_rvalid", 32'(rvalid[1]), 32'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rvalid[1] === 1'b1) seen++;
    end
    chk("midrst_no_rvalid", 32'(seen), 32'd0);
    chk("midrst_outstanding", 32'(outst[1]), 32'd0);

    // Randomized traffic on both instances
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 16; w++) begin
        issue(d, 1'b1, 32'(w * 4), 4'hF, $urandom);
        wait_resp(d, dat, e, n);
      end
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        req[d]   = ($urandom % 4) != 0;
        we[d]    = ($urandom % 2) != 0;
        be[d]    = 4'($urandom);
        stall[d] = ($urandom % 8) == 0;
        wdata[d] = $urandom;
        if (($urandom % 5) == 0) addr[d] = $urandom | 32'h1000;
        else addr[d] = (($urandom % 16) << 2) | ($urandom % 4);
      end
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin req[d] = 1'b0; stall[d] = 1'b0; end
    repeat (10) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
